// File: rtl/sop_burst_controller.sv
// sop_burst_controller: sequences one burst of BURST_LEN samples through the
// sum_of_products datapath. It holds a shadow coefficient set that is committed
// on job start, accepts samples over a valid/ready stream, tracks datapath
// latency with a valid pipe, and reports results with out_valid and end of job
// with done.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   start              job start request, honoured only in IDLE
//   busy, done         job in progress / one-cycle end-of-job pulse
//   cfg_we/addr/data   shadow coefficient write (0=c11 1=c12 2=c21 3=c22)
//   in_valid/ready     sample stream handshake, in_data is the sample
//   sop_data_in        sample presented to the datapath
//   sop_coef11..22     active coefficient set presented to the datapath
//   sop_final_sum      datapath result, SOP_LATENCY edges after sop_data_in
//   out_valid/out_sum  registered result for each accepted sample
//   stall_cnt          RUN cycles without in_valid, saturating
//                      (present only when SOP_PERF_EN is defined)
module sop_burst_controller #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned SOP_LATENCY = 2,
    parameter int unsigned BURST_LEN   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [DATA_WIDTH-1:0]     cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic [DATA_WIDTH-1:0]     sop_data_in,
    output logic [DATA_WIDTH-1:0]     sop_coef11,
    output logic [DATA_WIDTH-1:0]     sop_coef12,
    output logic [DATA_WIDTH-1:0]     sop_coef21,
    output logic [DATA_WIDTH-1:0]     sop_coef22,
    input  logic [2*DATA_WIDTH+1:0]   sop_final_sum,
    output logic                      out_valid,
    output logic [2*DATA_WIDTH+1:0]   out_sum
`ifdef SOP_PERF_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int unsigned SUM_W = 2 * DATA_WIDTH + 2;
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned VP_W  = SOP_LATENCY + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [3:0][DATA_WIDTH-1:0]      shadow_q, shadow_d;
    logic [3:0][DATA_WIDTH-1:0]      coef_q, coef_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [VP_W-1:0]                 vpipe_q, vpipe_d;
    logic [DATA_WIDTH-1:0]           data_d;
    logic [SUM_W-1:0]                out_sum_d;
    logic                            out_valid_d;
    logic                            busy_d, done_d, in_ready_d;
    logic                            beat;
`ifdef SOP_PERF_EN
    logic [15:0]                     stall_d;
`endif

    assign sop_coef11 = coef_q[0];
    assign sop_coef12 = coef_q[1];
    assign sop_coef21 = coef_q[2];
    assign sop_coef22 = coef_q[3];

    // in_ready is registered and high exactly while in RUN
    assign beat = in_valid & in_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        coef_d      = coef_q;
        cnt_d       = cnt_q;
        data_d      = sop_data_in;
        vpipe_d     = {vpipe_q[SOP_LATENCY-1:0], 1'b0};
        out_valid_d = vpipe_q[SOP_LATENCY];
        out_sum_d   = vpipe_q[SOP_LATENCY] ? sop_final_sum : out_sum;
`ifdef SOP_PERF_EN
        stall_d     = stall_cnt;
`endif

        // Shadow write first so a write coinciding with start is committed too
        if (cfg_we) begin
            shadow_d[cfg_addr] = cfg_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    coef_d  = shadow_d;
`ifdef SOP_PERF_EN
                    stall_d = 16'd0;
`endif
                end
            end
            ST_RUN: begin
                if (beat) begin
                    data_d     = in_data;
                    vpipe_d[0] = 1'b1;
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SOP_PERF_EN
                if (!in_valid && (stall_cnt != 16'hFFFF)) begin
                    stall_d = stall_cnt + 16'd1;
                end
`endif
            end
            ST_DRAIN: begin
                if (vpipe_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            coef_q      <= '0;
            cnt_q       <= '0;
            vpipe_q     <= '0;
            sop_data_in <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
`ifdef SOP_PERF_EN
            stall_cnt   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            coef_q      <= coef_d;
            cnt_q       <= cnt_d;
            vpipe_q     <= vpipe_d;
            sop_data_in <= data_d;
            out_valid   <= out_valid_d;
            out_sum     <= out_sum_d;
            busy        <= busy_d;
            done        <= done_d;
            in_ready    <= in_ready_d;
`ifdef SOP_PERF_EN
            stall_cnt   <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_sop_burst_controller.sv
// Directed testbench for sop_burst_controller with a two-stage datapath model:
// final_sum = registered(data_in) * (coef11+coef12+coef21+coef22), registered.
module tb_sop_burst_controller;

    localparam int unsigned DW = 4;
    localparam int unsigned SW = 2 * DW + 2;
    localparam int unsigned BL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [DW-1:0] cfg_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] sop_data_in, sop_coef11, sop_coef12, sop_coef21, sop_coef22;
    logic [SW-1:0] sop_final_sum;
    logic          out_valid;
    logic [SW-1:0] out_sum;
`ifdef SOP_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [SW-1:0] res_q[$];
    int            rcyc_q[$];

    sop_burst_controller #(
        .DATA_WIDTH (DW),
        .SOP_LATENCY(2),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sop_data_in  (sop_data_in),
        .sop_coef11   (sop_coef11),
        .sop_coef12   (sop_coef12),
        .sop_coef21   (sop_coef21),
        .sop_coef22   (sop_coef22),
        .sop_final_sum(sop_final_sum),
        .out_valid    (out_valid),
        .out_sum      (out_sum)
`ifdef SOP_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: two register stages
    logic [DW-1:0] dp_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_d          <= '0;
            sop_final_sum <= '0;
        end else begin
            dp_d          <= sop_data_in;
            sop_final_sum <= SW'(dp_d) * (SW'(sop_coef11) + SW'(sop_coef12)
                                        + SW'(sop_coef21) + SW'(sop_coef22));
        end
    end

    // Result and done monitor
    always @(negedge clk) begin
        if (out_valid) begin
            res_q.push_back(out_sum);
            rcyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_cfg(input logic [1:0] addr, input logic [DW-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_job();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream n beats (data 1..n), optional gap before beat gap_at, optional
    // start pokes in RUN and DRAIN; then check results, spacing and done.
    task automatic stream_job(input int n, input int gap_at, input int gap_len,
                              input bit poke, input int mult, input string tag);
        int first_beat, done_at, last_res, waited, d0, diff;
        res_q.delete(); rcyc_q.delete();
        d0 = done_cnt; first_beat = 0; done_at = 0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            start    = poke && (i == n / 2);
            @(negedge clk);
            if (i == 0) first_beat = cyc;
        end
        in_valid = 1'b0;
        start    = poke;
        @(negedge clk);
        start    = 1'b0;
        waited   = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        done_at = cyc;
        @(negedge clk);
        check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_result_count"}, 32'(res_q.size()), 32'(n));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        if (res_q.size() == n) begin
            check({tag, "_first_latency"}, 32'(rcyc_q[0] - first_beat), 32'd3);
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_sum%0d", tag, i), 32'(res_q[i]), 32'((i + 1) * mult));
                if (i > 0) begin
                    diff = (i == gap_at) ? gap_len + 1 : 1;
                    check($sformatf("%s_space%0d", tag, i), 32'(rcyc_q[i] - rcyc_q[i-1]), 32'(diff));
                end
            end
            last_res = rcyc_q[n-1];
            check({tag, "_done_after_last"}, 32'(done_at - last_res), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: reset mid-RUN with three beats in flight
        do_cfg(2'd0, 4'd1); do_cfg(2'd1, 4'd2); do_cfg(2'd2, 4'd3); do_cfg(2'd3, 4'd4);
        start_job();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = DW'(i + 1);
            @(negedge clk);
        end
        check("t1_pre_coef22", 32'(sop_coef22), 32'd4);
        res_q.delete(); rcyc_q.delete();
        rst = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_data_in", 32'(sop_data_in), 32'd0);
        check("t1_coef11", 32'(sop_coef11), 32'd0);
        check("t1_coef22", 32'(sop_coef22), 32'd0);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_no_results", 32'(res_q.size()), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: basic job, coefs 1..4 (sum 10)
        do_cfg(2'd0, 4'd1); do_cfg(2'd1, 4'd2); do_cfg(2'd2, 4'd3); do_cfg(2'd3, 4'd4);
        start_job();
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_in_ready", 32'(in_ready), 32'd1);
        stream_job(BL, -1, 0, 1'b0, 10, "t2");
`ifdef SOP_PERF_EN
        check("t2_stall", 32'(stall_cnt), 32'd0);
`endif

        // 3: two idle cycles between beats 3 and 4
        start_job();
        stream_job(BL, 3, 2, 1'b0, 10, "t3");
`ifdef SOP_PERF_EN
        check("t3_stall", 32'(stall_cnt), 32'd2);
`endif

        // 4: shadow write during RUN only affects the next job
        start_job();
        do_cfg(2'd0, 4'd15);
        check("t4_coef11_run", 32'(sop_coef11), 32'd1);
        stream_job(BL, -1, 0, 1'b0, 10, "t4a");
        check("t4_coef11_idle", 32'(sop_coef11), 32'd1);
        start_job();
        check("t4_coef11_new", 32'(sop_coef11), 32'd15);
        stream_job(BL, -1, 0, 1'b0, 24, "t4b");

        // 5: start pulses during RUN and DRAIN are ignored
        do_cfg(2'd0, 4'd1);
        start_job();
        stream_job(BL, -1, 0, 1'b1, 10, "t5");

        // 6: cfg write and start in the same IDLE cycle
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 4'd0; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        check("t6_coef22", 32'(sop_coef22), 32'd0);
        check("t6_coef11", 32'(sop_coef11), 32'd1);
        stream_job(BL, -1, 0, 1'b0, 6, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
